// File: rtl/gigex_tx_arbiter.sv
// Gigex transmit front end: round-robin arbitration over NCH word producers,
// MSB-byte-first serialisation onto the Gigex byte bus with per-channel full stalls.
module gigex_tx_arbiter #(
   parameter int WORD_BYTES = 16,
   parameter int NCH        = 8,
   parameter int FULL_DELAY = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [7:0]                  channel_full,
   input  logic [NCH*WORD_BYTES*8-1:0] data,
   input  logic [NCH-1:0]              valid,
   output logic [NCH-1:0]              ready,
   output logic [7:0]                  byte_out,
   output logic                        byte_out_valid,
   output logic [2:0]                  channel,
   output logic                        dbg_state
);

   localparam int WW = WORD_BYTES * 8;
   localparam int CW = $clog2(WORD_BYTES);

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   state_t                         r_state;
   logic [FULL_DELAY-1:0][NCH-1:0] r_full_pipe;
   logic [WW-1:0]                  r_latch;
   logic [CW-1:0]                  r_cnt;
   logic [2:0]                     r_channel;
   logic [2:0]                     r_last;

   logic [WW-1:0] w_words [8];
   logic [7:0]    w_full8;
   logic [7:0]    w_elig8;
   logic [7:0]    w_ready8;
   logic [3:0]    w_idx;
   logic [2:0]    w_sel;
   logic          w_found;
   logic          w_strobe;
   logic          w_last_byte;
   logic          w_arb_ok;
   logic          w_grant;

   for (genvar g = 0; g < 8; g++) begin : g_word
      if (g < NCH) begin : g_real
         assign w_words[g] = data[g*WW +: WW];
      end else begin : g_pad
         assign w_words[g] = '0;
      end
   end

   // Channels beyond NCH read as full and never eligible.
   always_comb begin
      w_full8 = '1;
      w_full8[NCH-1:0] = r_full_pipe[FULL_DELAY-1];
      w_elig8 = '0;
      w_elig8[NCH-1:0] = valid & ~r_full_pipe[FULL_DELAY-1];
   end

   always_comb begin
      w_found = 1'b0;
      w_sel   = r_last;
      w_idx   = '0;
      for (int k = 1; k <= NCH; k++) begin
         w_idx = {1'b0, r_last} + 4'(k);
         if (w_idx >= 4'(NCH)) w_idx = w_idx - 4'(NCH);
         if (!w_found && w_elig8[w_idx[2:0]]) begin
            w_found = 1'b1;
            w_sel   = w_idx[2:0];
         end
      end
   end

   // Handshake: word i transfers at a falling edge where valid[i] & ready[i];
   // ready is only offered in IDLE or on the strobed last byte of a word.
   assign w_strobe    = (r_state == S_BUSY) & ~w_full8[r_channel];
   assign w_last_byte = w_strobe & (r_cnt == '0);
   assign w_arb_ok    = (r_state == S_IDLE) | w_last_byte;
   assign w_grant     = w_arb_ok & w_found;
   assign w_ready8    = w_grant ? (8'd1 << w_sel) : 8'd0;

   assign ready          = w_ready8[NCH-1:0];
   assign byte_out       = (r_state == S_BUSY) ? r_latch[WW-1 -: 8] : 8'd0;
   assign byte_out_valid = w_strobe;
   assign channel        = r_channel;
   assign dbg_state      = (r_state == S_BUSY);

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_full_pipe <= '1;
         r_state     <= S_IDLE;
         r_latch     <= '0;
         r_cnt       <= '0;
         r_channel   <= '0;
         r_last      <= 3'(NCH-1);
      end else begin
         r_full_pipe[0] <= channel_full[NCH-1:0];
         for (int s = 1; s < FULL_DELAY; s++) r_full_pipe[s] <= r_full_pipe[s-1];
         if (w_grant) begin
            r_state   <= S_BUSY;
            r_latch   <= w_words[w_sel];
            r_cnt     <= CW'(WORD_BYTES-1);
            r_channel <= w_sel;
            r_last    <= w_sel;
         end else if (w_last_byte) begin
            r_state <= S_IDLE;
         end else if (w_strobe) begin
            r_latch <= {r_latch[WW-9:0], 8'd0};
            r_cnt   <= r_cnt - CW'(1);
         end
      end
   end

endmodule
